// File: rtl/rx_cmd_ctrl.sv
// rtl/rx_cmd_ctrl.sv - UART frame command decoder driving register writes and read-back transmit
// Commands: 0xAA addr data -> register write; 0xBB addr -> register read, result sent to TX.
module rx_cmd_ctrl #(
  parameter int width      = 8,
  parameter int addr_width = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Rx_D_VLD,
  input  logic [width-1:0]      Rx_P_Data,
  input  logic                  Rx_error,
  output logic [addr_width-1:0] Reg_Addr,
  output logic [width-1:0]      Reg_WrData,
  output logic                  Reg_WrEn,
  output logic                  Reg_RdEn,
  input  logic [width-1:0]      Reg_RdData,
  input  logic                  Reg_RdData_Valid,
  input  logic                  Tx_Busy,
  output logic [width-1:0]      Tx_P_Data,
  output logic                  Tx_D_VLD,
  output logic                  Frame_error,
  output logic                  Cmd_error,
  output logic                  Rd_timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, TX_WAIT, TX_SEND
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            tmo_cnt, tmo_cnt_nxt;
  logic [addr_width-1:0] addr_nxt;
  logic [width-1:0]      wrdata_nxt, txdata_nxt;
  logic                  frame_err_nxt, cmd_err_nxt, rd_tmo_nxt;
  logic                  good_frame, bad_frame;

  assign good_frame = Rx_D_VLD && !Rx_error;
  assign bad_frame  = Rx_D_VLD && Rx_error;

  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    addr_nxt      = Reg_Addr;
    wrdata_nxt    = Reg_WrData;
    txdata_nxt    = Tx_P_Data;
    frame_err_nxt = 1'b0;
    cmd_err_nxt   = 1'b0;
    rd_tmo_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bad_frame) begin
          frame_err_nxt = 1'b1;
        end else if (good_frame) begin
          if (Rx_P_Data == width'(8'hAA))      state_nxt = WR_ADDR;
          else if (Rx_P_Data == width'(8'hBB)) state_nxt = RD_ADDR;
          else                                 cmd_err_nxt = 1'b1;
        end
      end
      WR_ADDR, RD_ADDR, WR_DATA: begin
        if (bad_frame) begin
          frame_err_nxt = 1'b1;
          state_nxt     = IDLE;
        end else if (good_frame) begin
          if (state == WR_DATA) begin
            wrdata_nxt = Rx_P_Data;
            state_nxt  = WR_EXEC;
          end else begin
            addr_nxt = Rx_P_Data[addr_width-1:0];
            if (state == WR_ADDR) begin
              state_nxt = WR_DATA;
            end else begin
              tmo_cnt_nxt = '0;
              state_nxt   = RD_REQ;
            end
          end
        end
      end
      WR_EXEC: begin
        cmd_err_nxt = Rx_D_VLD;
        state_nxt   = IDLE;
      end
      RD_REQ: begin
        // tmo_cnt holds the number of RD_REQ cycles already spent without an acknowledge
        cmd_err_nxt = Rx_D_VLD;
        if (Reg_RdData_Valid) begin
          txdata_nxt = Reg_RdData;
          state_nxt  = TX_WAIT;
        end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
          rd_tmo_nxt = 1'b1;
          state_nxt  = IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      TX_WAIT: begin
        cmd_err_nxt = Rx_D_VLD;
        if (!Tx_Busy) state_nxt = TX_SEND;
      end
      TX_SEND: begin
        cmd_err_nxt = Rx_D_VLD;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they coincide with the state they belong to.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      Reg_Addr    <= '0;
      Reg_WrData  <= '0;
      Tx_P_Data   <= '0;
      Reg_WrEn    <= 1'b0;
      Reg_RdEn    <= 1'b0;
      Tx_D_VLD    <= 1'b0;
      Frame_error <= 1'b0;
      Cmd_error   <= 1'b0;
      Rd_timeout  <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      Reg_Addr    <= addr_nxt;
      Reg_WrData  <= wrdata_nxt;
      Tx_P_Data   <= txdata_nxt;
      Reg_WrEn    <= (state_nxt == WR_EXEC);
      Reg_RdEn    <= (state_nxt == RD_REQ);
      Tx_D_VLD    <= (state_nxt == TX_SEND);
      Frame_error <= frame_err_nxt;
      Cmd_error   <= cmd_err_nxt;
      Rd_timeout  <= rd_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// tb/tb_rx_cmd_ctrl.sv - randomized scenario bench for rx_cmd_ctrl
// Expectations come from command-level rules: pulse timing relative to frames, event counts.
module tb_rx_cmd_ctrl;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          Reset, Rx_D_VLD, Rx_error, Reg_RdData_Valid, Tx_Busy;
  logic [W-1:0]  Rx_P_Data, Reg_RdData, Reg_WrData, Tx_P_Data;
  logic [AW-1:0] Reg_Addr;
  logic          Reg_WrEn, Reg_RdEn, Tx_D_VLD, Frame_error, Cmd_error, Rd_timeout;

  int n_cmp = 0, n_err = 0;
  int n_wren = 0, n_rden = 0, n_txv = 0, n_ferr = 0, n_cerr = 0, n_tmo = 0;

  rx_cmd_ctrl #(.width(W), .addr_width(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset), .Rx_D_VLD(Rx_D_VLD), .Rx_P_Data(Rx_P_Data), .Rx_error(Rx_error),
    .Reg_Addr(Reg_Addr), .Reg_WrData(Reg_WrData), .Reg_WrEn(Reg_WrEn), .Reg_RdEn(Reg_RdEn),
    .Reg_RdData(Reg_RdData), .Reg_RdData_Valid(Reg_RdData_Valid), .Tx_Busy(Tx_Busy),
    .Tx_P_Data(Tx_P_Data), .Tx_D_VLD(Tx_D_VLD), .Frame_error(Frame_error),
    .Cmd_error(Cmd_error), .Rd_timeout(Rd_timeout)
  );

  always #5 CLK = ~CLK;

  // Event counters sampled mid-cycle.
  always @(negedge CLK) begin
    n_wren += int'(Reg_WrEn);
    n_rden += int'(Reg_RdEn);
    n_txv  += int'(Tx_D_VLD);
    n_ferr += int'(Frame_error);
    n_cerr += int'(Cmd_error);
    n_tmo  += int'(Rd_timeout);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] d, input logic e);
    Rx_D_VLD  = 1'b1;
    Rx_P_Data = d;
    Rx_error  = e;
    tick();
    Rx_D_VLD  = 1'b0;
    Rx_error  = 1'b0;
    Rx_P_Data = W'($urandom);
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [W-1:0] b);
    return AW'(int'(b) % (1 << AW));
  endfunction

  task automatic test_reset();
    n_cmp++;
    if ({Reg_Addr, Reg_WrData, Reg_WrEn, Reg_RdEn, Tx_P_Data, Tx_D_VLD,
         Frame_error, Cmd_error, Rd_timeout} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%h wd=%h we=%b re=%b tx=%h tv=%b fe=%b ce=%b to=%b want all 0",
               Reg_Addr, Reg_WrData, Reg_WrEn, Reg_RdEn, Tx_P_Data, Tx_D_VLD,
               Frame_error, Cmd_error, Rd_timeout);
    end
  endtask

  task automatic test_write(input logic [W-1:0] a, input logic [W-1:0] d, input int gap);
    int w0 = n_wren;
    send(8'hAA, 1'b0); idle(gap);
    send(a, 1'b0);     idle(gap);
    send(d, 1'b0);
    n_cmp++;
    if ({Reg_WrEn, Reg_RdEn, Reg_Addr, Reg_WrData} !== {1'b1, 1'b0, addr_of(a), d}) begin
      n_err++;
      $display("FAIL write_exec: got we=%b re=%b addr=%h wd=%h want we=1 re=0 addr=%h wd=%h",
               Reg_WrEn, Reg_RdEn, Reg_Addr, Reg_WrData, addr_of(a), d);
    end
    tick();
    n_cmp++;
    if ({Reg_WrEn, Reg_Addr, Reg_WrData} !== {1'b0, addr_of(a), d}) begin
      n_err++;
      $display("FAIL write_after: got we=%b addr=%h wd=%h want we=0 addr=%h wd=%h",
               Reg_WrEn, Reg_Addr, Reg_WrData, addr_of(a), d);
    end
    n_cmp++;
    if (n_wren - w0 !== 1) begin
      n_err++;
      $display("FAIL write_count: got %0d want 1", n_wren - w0);
    end
  endtask

  // lat: RD_REQ cycle (1-based) carrying the acknowledge; busy: Tx_Busy cycles in TX_WAIT;
  // inject: RD_REQ cycle in which a stray frame arrives (0 = none).
  task automatic test_read(input logic [W-1:0] a, input logic [W-1:0] rd,
                           input int lat, input int busy, input int inject);
    int r0 = n_rden, t0 = n_txv, c0 = n_cerr;
    Tx_Busy = (busy > 0);
    send(8'hBB, 1'b0);
    send(a, 1'b0);
    n_cmp++;
    if (Reg_Addr !== addr_of(a)) begin
      n_err++;
      $display("FAIL read_addr: got %h want %h", Reg_Addr, addr_of(a));
    end
    for (int k = 1; k <= lat; k++) begin
      n_cmp++;
      if ({Reg_RdEn, Reg_WrEn} !== 2'b10) begin
        n_err++;
        $display("FAIL read_rden: cycle %0d got re=%b we=%b want re=1 we=0", k, Reg_RdEn, Reg_WrEn);
      end
      if (k == inject) begin
        Rx_D_VLD  = 1'b1;
        Rx_P_Data = 8'hAA;
      end
      if (k == lat) begin
        Reg_RdData_Valid = 1'b1;
        Reg_RdData       = rd;
      end
      tick();
      Rx_D_VLD         = 1'b0;
      Reg_RdData_Valid = 1'b0;
      Reg_RdData       = W'($urandom);
      if (k == inject) begin
        n_cmp++;
        if (Cmd_error !== 1'b1) begin
          n_err++;
          $display("FAIL read_drop_cmderr: got %b want 1", Cmd_error);
        end
      end
    end
    n_cmp++;
    if ({Reg_RdEn, Tx_P_Data} !== {1'b0, rd}) begin
      n_err++;
      $display("FAIL read_latch: got re=%b tx=%h want re=0 tx=%h", Reg_RdEn, Tx_P_Data, rd);
    end
    for (int j = 0; j < busy; j++) begin
      n_cmp++;
      if (Tx_D_VLD !== 1'b0) begin
        n_err++;
        $display("FAIL tx_wait_busy: cycle %0d got %b want 0", j, Tx_D_VLD);
      end
      tick();
    end
    Tx_Busy = 1'b0;
    n_cmp++;
    if (Tx_D_VLD !== 1'b0) begin
      n_err++;
      $display("FAIL tx_wait_free: got %b want 0", Tx_D_VLD);
    end
    tick();
    n_cmp++;
    if ({Tx_D_VLD, Tx_P_Data} !== {1'b1, rd}) begin
      n_err++;
      $display("FAIL tx_send: got tv=%b tx=%h want tv=1 tx=%h", Tx_D_VLD, Tx_P_Data, rd);
    end
    tick();
    n_cmp++;
    if ({Tx_D_VLD, Tx_P_Data} !== {1'b0, rd}) begin
      n_err++;
      $display("FAIL tx_after: got tv=%b tx=%h want tv=0 tx=%h", Tx_D_VLD, Tx_P_Data, rd);
    end
    n_cmp++;
    if ({n_rden - r0, n_txv - t0, n_cerr - c0} !== {lat, 1, int'(inject > 0)}) begin
      n_err++;
      $display("FAIL read_counts: got rden=%0d tx=%0d cerr=%0d want rden=%0d tx=1 cerr=%0d",
               n_rden - r0, n_txv - t0, n_cerr - c0, lat, int'(inject > 0));
    end
  endtask

  task automatic test_timeout(input logic [W-1:0] a);
    int r0 = n_rden, m0 = n_tmo;
    send(8'hBB, 1'b0);
    send(a, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      n_cmp++;
      if ({Reg_RdEn, Rd_timeout} !== 2'b10) begin
        n_err++;
        $display("FAIL timeout_wait: cycle %0d got re=%b to=%b want re=1 to=0", k, Reg_RdEn, Rd_timeout);
      end
      tick();
    end
    n_cmp++;
    if ({Reg_RdEn, Rd_timeout} !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_pulse: got re=%b to=%b want re=0 to=1", Reg_RdEn, Rd_timeout);
    end
    tick();
    n_cmp++;
    if ({Rd_timeout, n_rden - r0, n_tmo - m0} !== {1'b0, TO, 1}) begin
      n_err++;
      $display("FAIL timeout_counts: got to=%b rden=%0d tmo=%0d want to=0 rden=%0d tmo=1",
               Rd_timeout, n_rden - r0, n_tmo - m0, TO);
    end
  endtask

  // pos: which frame carries the error (0 command, 1 write addr, 2 write data, 3 read addr).
  task automatic test_frame_error(input int pos);
    int w0 = n_wren, r0 = n_rden, f0 = n_ferr;
    case (pos)
      0: send(W'($urandom), 1'b1);
      1: begin send(8'hAA, 1'b0); send(8'h05, 1'b1); end
      2: begin send(8'hAA, 1'b0); send(8'h05, 1'b0); send(W'($urandom), 1'b1); end
      default: begin send(8'hBB, 1'b0); send(8'h05, 1'b1); end
    endcase
    n_cmp++;
    if ({Frame_error, Reg_WrEn, Reg_RdEn} !== 3'b100) begin
      n_err++;
      $display("FAIL frame_err_pulse: pos %0d got fe=%b we=%b re=%b want fe=1 we=0 re=0",
               pos, Frame_error, Reg_WrEn, Reg_RdEn);
    end
    idle(2);
    n_cmp++;
    if ({Frame_error, n_wren - w0, n_rden - r0, n_ferr - f0} !== {1'b0, 0, 0, 1}) begin
      n_err++;
      $display("FAIL frame_err_counts: pos %0d got fe=%b we=%0d re=%0d fe_n=%0d want 0 0 0 1",
               pos, Frame_error, n_wren - w0, n_rden - r0, n_ferr - f0);
    end
  endtask

  task automatic test_cmd_error(input logic [W-1:0] c);
    int c0 = n_cerr;
    send(c, 1'b0);
    n_cmp++;
    if (Cmd_error !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_err_pulse: cmd %h got %b want 1", c, Cmd_error);
    end
    tick();
    n_cmp++;
    if ({Cmd_error, n_cerr - c0} !== {1'b0, 1}) begin
      n_err++;
      $display("FAIL cmd_err_single: got ce=%b n=%0d want ce=0 n=1", Cmd_error, n_cerr - c0);
    end
  endtask

  task automatic test_reset_mid();
    int w0, r0, m0;
    send(8'hAA, 1'b0);
    send(8'h09, 1'b0);
    w0 = n_wren;
    Reset = 1'b1; Rx_D_VLD = 1'b1; Rx_P_Data = 8'h3C;
    tick();
    Reset = 1'b0; Rx_D_VLD = 1'b0;
    test_reset();
    idle(3);
    n_cmp++;
    if ({Reg_WrEn, n_wren - w0} !== {1'b0, 0}) begin
      n_err++;
      $display("FAIL reset_wr_abandon: got we=%b n=%0d want 0 0", Reg_WrEn, n_wren - w0);
    end
    send(8'hBB, 1'b0);
    send(8'h03, 1'b0);
    idle(2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    r0 = n_rden; m0 = n_tmo;
    test_reset();
    idle(TO + 3);
    n_cmp++;
    if ({n_rden - r0, n_tmo - m0, Reg_RdEn} !== {0, 0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_rd_abandon: got rden=%0d tmo=%0d want 0 0", n_rden - r0, n_tmo - m0);
    end
  endtask

  initial begin
    logic [W-1:0] c;
    int lat;
    Reset = 1'b1; Rx_D_VLD = 1'b0; Rx_error = 1'b0; Rx_P_Data = '0;
    Reg_RdData = '0; Reg_RdData_Valid = 1'b0; Tx_Busy = 1'b0;
    idle(2);
    test_reset();
    Reset = 1'b0;
    tick();
    test_reset();

    test_write(8'h05, 8'h3C, 0);
    for (int i = 0; i < 6; i++) test_write(W'($urandom), W'($urandom), $urandom_range(0, 3));

    test_read(8'h02, 8'h7E, 3, 0, 0);
    test_read(W'($urandom), W'($urandom), 1, 0, 0);
    test_read(W'($urandom), W'($urandom), TO, 0, 0);
    test_read(W'($urandom), W'($urandom), 2, 10, 0);
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, TO);
      test_read(W'($urandom), W'($urandom), lat, $urandom_range(0, 4), $urandom_range(0, lat));
    end

    for (int p = 0; p < 4; p++) test_frame_error(p);
    test_frame_error(1);
    test_read(8'h06, W'($urandom), 2, 0, 0);

    test_cmd_error(8'h11);
    for (int i = 0; i < 4; i++) begin
      c = W'($urandom);
      if (c == 8'hAA || c == 8'hBB) c = 8'h00;
      test_cmd_error(c);
    end

    test_timeout(W'($urandom));
    test_reset_mid();
    test_write(W'($urandom), W'($urandom), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rx_cmd_ctrl.md
RX_CMD_CTRL -- requirements
Module: rx_cmd_ctrl

Interface
REQ-001 The block SHALL take parameter width, default 8, as the frame data width in bits.
REQ-002 The block SHALL take parameter addr_width, default 4, as the register address width; it SHALL satisfy addr_width <= width.
REQ-003 The block SHALL take parameter TIMEOUT, default 16, as the maximum read-wait cycles; it SHALL satisfy 2 <= TIMEOUT <= 255.
REQ-004 The block SHALL have one clock CLK; reset Reset SHALL be synchronous and active-high.
REQ-005 Ports SHALL be, in order (name direction width meaning):
- CLK  in  1  clock, all logic on rising edge
- Reset  in  1  synchronous active-high reset
- Rx_D_VLD  in  1  one-cycle pulse, received frame present
- Rx_P_Data  in  width  received frame data, valid with Rx_D_VLD
- Rx_error  in  1  parity or stop error of the frame, qualified by Rx_D_VLD
- Reg_Addr  out  addr_width  register address
- Reg_WrData  out  width  register write data
- Reg_WrEn  out  1  register write strobe
- Reg_RdEn  out  1  register read request, held until acknowledged
- Reg_RdData  in  width  register read data
- Reg_RdData_Valid  in  1  read acknowledge, qualifies Reg_RdData
- Tx_Busy  in  1  transmitter busy
- Tx_P_Data  out  width  byte to transmit
- Tx_D_VLD  out  1  one-cycle transmit request
- Frame_error  out  1  one-cycle pulse, frame aborted on Rx_error
- Cmd_error  out  1  one-cycle pulse, unknown command or overrun
- Rd_timeout  out  1  one-cycle pulse, read not acknowledged

Function
REQ-006 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_REQ, TX_WAIT, TX_SEND; all outputs SHALL be driven from registers.
REQ-007 In IDLE, Rx_D_VLD=1 with Rx_error=0 SHALL move to WR_ADDR if Rx_P_Data=0xAA, to RD_ADDR if 0xBB, else pulse Cmd_error next cycle and stay in IDLE.
REQ-008 In WR_ADDR or RD_ADDR, a good frame SHALL latch Rx_P_Data[addr_width-1:0] into Reg_Addr; the FSM SHALL then move to WR_DATA or RD_REQ respectively.
REQ-009 In WR_DATA, a good frame SHALL latch Rx_P_Data into Reg_WrData and move to WR_EXEC.
REQ-010 WR_EXEC SHALL last exactly one cycle with Reg_WrEn=1, i.e. the cycle after the data frame's Rx_D_VLD; the FSM SHALL then return to IDLE.
REQ-011 Reg_RdEn SHALL be 1 in every RD_REQ cycle; the first such cycle SHALL be the cycle after the address frame.
REQ-012 In RD_REQ, Reg_RdData_Valid=1 SHALL latch Reg_RdData into Tx_P_Data and move to TX_WAIT; valid in the first RD_REQ cycle SHALL be accepted.
REQ-013 A timeout counter SHALL clear on entry to RD_REQ; if no valid arrives within TIMEOUT RD_REQ cycles, the FSM SHALL return to IDLE and pulse Rd_timeout once; if valid arrives on the TIMEOUT-th cycle, the read SHALL win.
REQ-014 In TX_WAIT, Tx_Busy=0 SHALL move to TX_SEND; Tx_Busy=1 SHALL hold the state with no timeout.
REQ-015 TX_SEND SHALL last exactly one cycle with Tx_D_VLD=1, Tx_P_Data stable; the FSM SHALL then return to IDLE.
REQ-016 Rx_D_VLD=1 with Rx_error=1 in IDLE, WR_ADDR, WR_DATA or RD_ADDR SHALL pulse Frame_error next cycle and return to IDLE; no register access SHALL occur.
REQ-017 Rx_D_VLD in WR_EXEC, RD_REQ, TX_WAIT or TX_SEND SHALL be dropped and pulse Cmd_error next cycle; the state sequence SHALL be unaffected.
REQ-018 Reg_Addr, Reg_WrData and Tx_P_Data SHALL hold their last value until next latched.
REQ-019 Reg_WrEn and Reg_RdEn SHALL never be 1 in the same cycle; each error output SHALL be 1 for exactly one cycle per event.

Reset
REQ-020 Reset=1 at a rising edge SHALL force IDLE and zero all outputs, latched registers and the timeout counter, overriding all other inputs.
REQ-021 Reset mid-command SHALL abandon the command with no Reg_WrEn, Reg_RdEn, Tx_D_VLD or error pulse afterwards.

Verification
REQ-022 Frames 0xAA,0x05,0x3C -> one Reg_WrEn pulse the cycle after the third frame, Reg_Addr=5, Reg_WrData=0x3C.
REQ-023 Frames 0xBB,0x02; Reg_RdData=0x7E valid 3 cycles later; Tx_Busy=0 -> Reg_RdEn high 3 cycles, then Tx_D_VLD pulse with Tx_P_Data=0x7E.
REQ-024 Frame 0xAA, then 0x05 with Rx_error=1 -> Frame_error pulse, FSM in IDLE, no Reg_WrEn; a following 0xBB command SHALL work.
REQ-025 Frame 0x11 -> Cmd_error pulse; read with no acknowledge -> Rd_timeout after exactly TIMEOUT Reg_RdEn cycles.
REQ-026 Read acknowledged while Tx_Busy=1 for 10 cycles -> Tx_D_VLD 1 cycle after Tx_Busy falls; Reset asserted in WR_DATA -> all outputs 0, no Reg_WrEn.
